save_upload_server: RTL and testbench

// - Upload-side responder for the HPS ioctl channel. Serves save data (hiscore/NVRAM image) back to
//   the HPS when it reads the core, and raises ioctl_upload_req once the save image is dirty and quiet.
// - Sits between hps_io (ioctl_upload/ioctl_rd/ioctl_addr/ioctl_din) and a 1-cycle-latency sync save RAM.
//

---
 rtl/save_upload_server.sv | 200 ++++++++++++++++++++
 tb/tb_save_upload_server.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/save_upload_server.sv
// save_upload_server
//   Upload-side responder for the HPS ioctl channel. Serves bytes of the
//   save image (hiscore / NVRAM) from a 1-cycle-latency synchronous RAM when
//   the HPS reads the core. Raises a one-cycle ioctl_upload_req once the image
//   is dirty, autosave is enabled and the core has been quiet long enough.
//
//   Optional feature macro: UPLOAD_CHECKSUM_EN
//     When defined, the image grows by two bytes. Address SIZE returns the low
//     byte and address SIZE+1 the high byte of a 16-bit running sum of every
//     byte served from the RAM during the current upload session.
//
//   Read handshake: one read is accepted per ioctl_rd strobe while the FSM is
//   IDLE and the session is active (upload high, index matches). The byte is
//   presented on ioctl_din in the WAIT cycle, two cycles after the strobe, and
//   is held afterwards until the next read reaches WAIT. Strobes arriving
//   while busy are dropped; hps_io spaces them at least three cycles apart.
//
//   dbg_state exposes the read FSM state (0 IDLE, 1 FETCH, 2 WAIT).
module save_upload_server #(
  parameter int ADDR_W     = 10,
  parameter int SAVE_INDEX = 4,
  parameter int HOLDOFF_W  = 20
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  input  logic              save_wr,
  input  logic              autosave,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [24:0] SIZE_A = 25'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [24:0]           addr_q, addr_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic                  ram_rd_q, ram_rd_d;
  logic [7:0]            din_q, din_d;
  logic [7:0]            read_byte;

  logic                  active;
  logic                  active_q;
  logic                  fall;
  logic                  accept;

  logic                  dirty_q, dirty_d;
  logic                  req_sent_q, req_sent_d;
  logic [HOLDOFF_W-1:0]  holdoff_q, holdoff_d;
  logic                  req;

  assign active = ioctl_upload & (ioctl_index == 8'(SAVE_INDEX));
  assign fall   = active_q & ~active;
  assign accept = (state_q == S_IDLE) & ioctl_rd & active;

`ifdef UPLOAD_CHECKSUM_EN
  logic        rise;
  logic [15:0] sum_q, sum_d;

  assign rise = ~active_q & active;

  // Byte served for the latched address: RAM data, checksum bytes, or pad.
  always_comb begin
    read_byte = 8'hFF;
    if (addr_q < SIZE_A)               read_byte = ram_q;
    else if (addr_q == SIZE_A)         read_byte = sum_q[7:0];
    else if (addr_q == SIZE_A + 25'd1) read_byte = sum_q[15:8];
  end

  // Running sum of RAM bytes served this session; restarts when a session opens.
  always_comb begin
    sum_d = sum_q;
    if (rise)
      sum_d = 16'h0000;
    else if ((state_q == S_WAIT) && (addr_q < SIZE_A))
      sum_d = sum_q + {8'h00, ram_q};
  end

  // Checksum register.
  always_ff @(posedge clk_sys) begin
    if (reset) sum_q <= 16'h0000;
    else       sum_q <= sum_d;
  end
`else
  // Byte served for the latched address: RAM data inside the image, pad beyond.
  always_comb begin
    read_byte = 8'hFF;
    if (addr_q < SIZE_A) read_byte = ram_q;
  end
`endif

  // Read FSM next-state and datapath: IDLE accepts, FETCH drives the RAM, WAIT captures.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    din_d      = din_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FETCH;
          addr_d  = ioctl_addr;
          if (ioctl_addr < SIZE_A) begin
            ram_addr_d = ioctl_addr[ADDR_W-1:0];
            ram_rd_d   = 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_IDLE;
        din_d   = read_byte;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read FSM and datapath registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= 25'd0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      din_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      din_q      <= din_d;
    end
  end

  // Upload request: fire once the image is dirty and quiet, at most once per session gap.
  always_comb begin
    req = dirty_q & autosave & (holdoff_q == '0) & ~active & ~req_sent_q;

    holdoff_d = holdoff_q;
    if (save_wr)
      holdoff_d = '1;
    else if (holdoff_q != '0)
      holdoff_d = holdoff_q - HOLDOFF_W'(1);

    dirty_d = dirty_q;
    if (save_wr)
      dirty_d = 1'b1;
    else if (fall)
      dirty_d = 1'b0;

    req_sent_d = req_sent_q;
    if (fall)
      req_sent_d = 1'b0;
    else if (req)
      req_sent_d = 1'b1;
  end

  // Dirty tracking, quiet-time counter and session edge detector registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active_q   <= 1'b0;
      dirty_q    <= 1'b0;
      req_sent_q <= 1'b0;
      holdoff_q  <= '1;
    end else begin
      active_q   <= active;
      dirty_q    <= dirty_d;
      req_sent_q <= req_sent_d;
      holdoff_q  <= holdoff_d;
    end
  end

  // The WAIT cycle forwards the RAM byte directly so it appears two cycles after the strobe.
  assign ioctl_din        = (state_q == S_WAIT) ? read_byte : din_q;
  assign ioctl_upload_req = req;
  assign ram_addr         = ram_addr_q;
  assign ram_rd           = ram_rd_q;
  assign busy             = (state_q != S_IDLE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_save_upload_server.sv
// Testbench for save_upload_server (small image, short holdoff).
module tb_save_upload_server;

  localparam int ADDR_W     = 4;
  localparam int SIZE       = 16;
  localparam int SAVE_INDEX = 4;
  localparam int HW         = 4;
  localparam int QUIET      = 16;  // cycles from save_wr cycle to first eligible request cycle

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_upload_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              save_wr;
  logic              autosave;
  logic              busy;
  logic [1:0]        dbg_state;

  save_upload_server #(
    .ADDR_W(ADDR_W), .SAVE_INDEX(SAVE_INDEX), .HOLDOFF_W(HW)
  ) dut (
    .clk_sys(clk), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
    .save_wr(save_wr), .autosave(autosave), .busy(busy), .dbg_state(dbg_state)
  );

  // Behavioural save RAM with one cycle of read latency.
  logic [7:0] mem [SIZE];
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  // ---------------- scoreboard / reference model ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];

  int          cyc = 0;
  int          last_wr = 0;     // cycle of the last holdoff reload (save_wr or reset)
  bit          m_valid = 0;
  bit          m_dirty = 0;
  bit          m_sent = 0;
  bit          m_prev_act = 0;
  logic [15:0] m_sum = 16'h0;
  logic [7:0]  m_din = 8'hFF;
  int          pulses = 0;
  int          last_pulse = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit act_now();
    return ioctl_upload && (ioctl_index == 8'(SAVE_INDEX));
  endfunction

  // One clock cycle: check the request output mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit exp_req, cur, fall, rise;
    @(negedge clk);
    exp_req = m_dirty && autosave && ((cyc - last_wr) >= QUIET) && !act_now() && !m_sent;
    if (m_valid) begin
      check("upload_req", ioctl_upload_req, exp_req);
      if (ioctl_upload_req) begin pulses++; last_pulse = cyc; end
    end
    @(posedge clk);
    if (reset) begin
      m_valid = 1; m_dirty = 0; m_sent = 0; m_prev_act = 0;
      m_sum = 16'h0; m_din = 8'hFF; last_wr = cyc;
    end else begin
      cur  = act_now();
      fall = m_prev_act && !cur;
      rise = !m_prev_act && cur;
      if (fall) m_sent = 0; else if (exp_req) m_sent = 1;
      if (save_wr) begin m_dirty = 1; last_wr = cyc; end
      else if (fall) m_dirty = 0;
      if (rise) m_sum = 16'h0;
      m_prev_act = cur;
    end
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expected byte for an image address under the current model state.
  function automatic logic [7:0] image_byte(input int a);
    if (a < SIZE) return mem[a];
`ifdef UPLOAD_CHECKSUM_EN
    if (a == SIZE)     return m_sum[7:0];
    if (a == SIZE + 1) return m_sum[15:8];
`endif
    return 8'hFF;
  endfunction

  // ---------------- driver: one HPS read strobe, checked cycle by cycle ----------------
  task automatic do_read(input int a, input bit drop);
    bit         acc;
    logic [7:0] e;
    acc = act_now();
    if (acc) begin
      exp_q.push_back(image_byte(a));
      if (a < SIZE) m_sum = m_sum + {8'h00, mem[a]};
    end
    ioctl_rd = 1'b1; ioctl_addr = 25'(a);
    tick();
    ioctl_rd = 1'b0;
    if (drop) ioctl_upload = 1'b0;
    // strobe + 1
    if (acc) begin
      check("ram_rd@1", ram_rd, (a < SIZE));
      if (a < SIZE) check("ram_addr@1", ram_addr, a % SIZE);
      check("busy@1", busy, 1);
      check("state@1", dbg_state, 1);
    end else begin
      check("ram_rd_idle", ram_rd, 0);
      check("busy_idle", busy, 0);
    end
    tick();
    // strobe + 2
    check("ram_rd@2", ram_rd, 0);
    if (acc) begin
      e = exp_q.pop_front();
      check("busy@2", busy, 1);
      check("din@2", ioctl_din, e);
      m_din = e;
    end else begin
      check("din_hold", ioctl_din, m_din);
    end
    tick();
    // strobe + 3
    check("busy@3", busy, 0);
    check("din@3", ioctl_din, m_din);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p0;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = 25'd0; save_wr = 1'b0; autosave = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom_range(0, 255));
    ticks(2);
    reset = 1'b0;
    check("rst_din", ioctl_din, 8'hFF);
    check("rst_req", ioctl_upload_req, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    tick();

    // Basic read of a preloaded byte.
    mem[5] = 8'hA5;
    ioctl_upload = 1'b1; ioctl_index = 8'(SAVE_INDEX);
    tick();
    do_read(5, 0);
    check("a5_value", ioctl_din, 8'hA5);
    // Just past the image.
    do_read(SIZE, 0);
    do_read(SIZE + 2, 0);
    // Wrong index: strobe ignored, output held.
    ioctl_index = 8'd3;
    do_read(7, 0);
    ioctl_index = 8'(SAVE_INDEX);
    // Session drops during a read; the read still completes.
    do_read(9, 1);
    ticks(2);

    // Checksum over the whole image in a fresh session.
    for (int i = 0; i < SIZE; i++) mem[i] = (i % 3 == 0) ? 8'h01 : (i % 3 == 1) ? 8'h02 : 8'hFF;
    ioctl_upload = 1'b1; tick();
    for (int i = 0; i < SIZE + 3; i++) do_read(i, 0);
`ifdef UPLOAD_CHECKSUM_EN
    check("sum_lo_const", ioctl_din == 8'hFF ? 16'h050B : 16'h0, 16'h050B);
`endif
    ioctl_upload = 1'b0; ticks(2);

    // Single save_wr with autosave: one pulse QUIET cycles later, never repeated.
    autosave = 1'b1;
    ticks(20);
    p0 = pulses;
    save_wr = 1'b1; tick(); save_wr = 1'b0;
    ticks(30);
    check("one_pulse", pulses - p0, 1);
    check("pulse_delay", last_pulse - last_wr, QUIET);

    // Session ends in the same cycle as save_wr: image stays dirty, new request follows.
    ioctl_upload = 1'b1; ticks(3);
    p0 = pulses;
    ioctl_upload = 1'b0; save_wr = 1'b1; tick(); save_wr = 1'b0;
    ticks(25);
    check("dirty_kept_pulse", pulses - p0, 1);

    // Session ends without save_wr: image clean, no request.
    ioctl_upload = 1'b1; ticks(3);
    p0 = pulses;
    ioctl_upload = 1'b0; ticks(25);
    check("clean_no_pulse", pulses - p0, 0);

    // Reset in the middle of a read.
    ioctl_upload = 1'b1; tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd3; tick(); ioctl_rd = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_din", ioctl_din, 8'hFF);
    check("midrst_ram_rd", ram_rd, 0);
    tick();

    // Randomized traffic: sessions, index, save writes, autosave and reads.
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) ioctl_upload = ~ioctl_upload;
      if ($urandom_range(0, 9) == 0) ioctl_index = ($urandom_range(0, 3) == 0) ? 8'd3 : 8'(SAVE_INDEX);
      if ($urandom_range(0, 19) == 0) autosave = ~autosave;
      save_wr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) do_read($urandom_range(0, SIZE + 3), 0);
      else tick();
    end
    save_wr = 1'b0;
    ticks(2);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
